immediate_encoder: RTL and testbench
====================================

Name: immediate_encoder

Overview:
- Inverse of the decode-stage immediate extractor: packs a 32-bit signed immediate plus register and opcode fields into a 32-bit RV32I instruction word in U/J/I/S/B format.
- Also expands the LI pseudo-instruction into ADDI, or into a LUI+ADDI pair.
- Used by the instruction-memory preload path and by the self-test stimulus generator.
- Valid/ready on both sides, one registered output stage, and a small FSM for two-beat LI expansion.

Parameters:
- XLEN, 32, data and instruction width (fixed 32; present for readability only).

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  encoder can accept a request this cycle.
- FORMAT  in  3  0=U, 1=J, 2=I, 3=S, 4=B, 5=LI, 6-7 illegal.
- OPCODE  in  7  opcode field; ignored for LI.
- FUNCT3  in  3  funct3 field; ignored for U, J and LI.
- RD  in  5  destination register.
- RS1  in  5  source register 1.
- RS2  in  5  source register 2.
- IMM  in  32  immediate as a signed value, byte offset for branches and jumps.
- OUT_VALID  out  1  INSTRUCTION valid.
- OUT_READY  in  1  consumer accepts INSTRUCTION.
- INSTRUCTION  out  32  encoded word.
- ERR  out  1  range or alignment violation for the word currently presented.

Behaviour:
- Reset (async, RESET_N=0):
  - OUT_VALID=0, INSTRUCTION=0, ERR=0, FSM=IDLE.
  - IN_READY=0 while RESET_N=0.
  - Reset mid-LI drops the pending second beat.
- Acceptance and latency:
  - IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY).
  - A request is accepted on an edge where IN_VALID && IN_READY.
  - The encoded word is registered, and OUT_VALID is asserted the next cycle (latency 1).
- Output hold: INSTRUCTION and ERR hold stable while OUT_VALID && !OUT_READY.
- Throughput: with OUT_READY held high, one word per cycle.
- Packing (imm bits shown high to low):
  - U: IMM[31:12], RD, OPCODE. ERR if IMM[11:0] is non-zero.
  - J: IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD, OPCODE. ERR if IMM[31:20] is not all equal to IMM[20], or if IMM[0]=1.
  - I: IMM[11:0], RS1, FUNCT3, RD, OPCODE. ERR if IMM[31:11] is not uniform.
  - S: IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0], OPCODE. Same range rule as I.
  - B: IMM[12], IMM[10:5], RS2, RS1, FUNCT3, IMM[4:1], IMM[11], OPCODE. ERR if IMM[31:12] is not uniform, or if IMM[0]=1.
  - On ERR the word is still emitted with truncated fields.
  - Illegal FORMAT: INSTRUCTION=0, ERR=1.
- LI expansion:
  - If IMM fits signed 12 bits: emit a single ADDI RD,x0,IMM[11:0] (opcode 0010011, funct3 000).
  - Otherwise:
    - lo = IMM[11:0].
    - hi = (IMM + 0x800)[31:12], 32-bit wrap-around permitted.
    - Beat 1: LUI RD,hi (opcode 0110111).
    - Beat 2: ADDI RD,RD,lo.
  - The FSM latches RD and lo on acceptance.
  - LI never asserts ERR.
- FSM:
  - IDLE→SECOND on acceptance of a two-beat LI.
  - SECOND: beat 2 loads into the output register on the cycle beat 1 is consumed (OUT_READY=1), then the FSM returns to IDLE.
  - IN_READY=0 throughout SECOND.
  - Back-to-back: the beat-2 handoff and beat-1 consumption occur on the same edge, with no bubble.

Decomposition:
- Shared include header encoder_defs.vh holds:
  - FORMAT codes FMT_U..FMT_LI.
  - OPC_LUI=0110111, OPC_OPIMM=0010011.
  - FUNCT3_ADDI=000.
- Sub-module imm_field_pack: purely combinational. Takes FORMAT, the fields and IMM, and returns the packed word plus the range/alignment error bit. It is instantiated once, in front of the output register.
- The top level holds the handshake, the LI FSM and the output register.

Test Plan:
1. Single-word I and B formats:
   - I: FORMAT=I, OPCODE=0010011, FUNCT3=0, RD=5, RS1=6, IMM=0xFFFFFFFF → one cycle later INSTRUCTION=0xFFF30293, ERR=0.
   - B: FORMAT=B, OPCODE=1100011, FUNCT3=0, RS1=1, RS2=2, IMM=8 → 0x00208463, ERR=0.
   - B with IMM=7 → ERR=1.
2. LI two-beat expansion:
   - RD=10, IMM=0x12345678, OUT_READY=1 → consecutive words 0x12345537 then 0x67850513. IN_READY=0 for one cycle.
   - RD=10, IMM=0x00000FFF (rounding case) → 0x00001537 then 0xFFF50513.
3. LI single beat: RD=10, IMM=0xFFFFFFFB → single word 0xFFB00513. FSM stays IDLE and IN_READY stays high.
4. Backpressure: OUT_READY=0 for 3 cycles during an LI beat 1 → OUT_VALID=1 and INSTRUCTION=0x12345537 stable, IN_READY=0. On release, beat 2 follows on the next cycle.
5. Reset mid-operation: drive RESET_N low asynchronously (between edges) while in SECOND → OUT_VALID=0 and INSTRUCTION=0 immediately. After release, IN_READY=1 and no stray ADDI appears.
6. Illegal FORMAT=7 → INSTRUCTION=0, ERR=1. The next request encodes normally.

Source files
------------

// File: rtl/immediate_encoder_pkg.sv
// Shared constants for the RV32I immediate encoder: format codes, opcodes and a range helper.
package immediate_encoder_pkg;

  localparam logic [2:0] FmtU  = 3'd0;
  localparam logic [2:0] FmtJ  = 3'd1;
  localparam logic [2:0] FmtI  = 3'd2;
  localparam logic [2:0] FmtS  = 3'd3;
  localparam logic [2:0] FmtB  = 3'd4;
  localparam logic [2:0] FmtLi = 3'd5;

  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [2:0] Funct3Addi = 3'b000;

  // True when value is representable as a signed integer of the given bit width.
  function automatic logic fits_signed(logic [31:0] value, int unsigned width);
    logic signed [31:0] ext;
    ext = $signed(value << (32 - width)) >>> (32 - width);
    return ext == $signed(value);
  endfunction

endpackage

// File: rtl/immediate_encoder_field_pack.sv
// Combinational RV32I field packer: scatters the immediate per format and flags range/alignment.
module imm_field_pack
  import immediate_encoder_pkg::*;
(
  input  logic [2:0]  format_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_o
);

  always_comb begin
    word_o = 32'h0;
    err_o  = 1'b0;
    case (format_i)
      FmtU: begin
        word_o = {imm_i[31:12], rd_i, opcode_i};
        err_o  = |imm_i[11:0];
      end
      FmtJ: begin
        word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        err_o  = !fits_signed(imm_i, 21) || imm_i[0];
      end
      FmtI: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        err_o  = !fits_signed(imm_i, 12);
      end
      FmtS: begin
        word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        err_o  = !fits_signed(imm_i, 12);
      end
      FmtB: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11],
                  opcode_i};
        err_o  = !fits_signed(imm_i, 13) || imm_i[0];
      end
      // LI is rewritten into I/U by the caller; anything reaching here is illegal.
      default: begin
        word_o = 32'h0;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/immediate_encoder.sv
// RV32I immediate encoder: valid/ready handshake, registered output and two-beat LI expansion.
module immediate_encoder
  import immediate_encoder_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [2:0]      FORMAT,
  input  logic [6:0]      OPCODE,
  input  logic [2:0]      FUNCT3,
  input  logic [4:0]      RD,
  input  logic [4:0]      RS1,
  input  logic [4:0]      RS2,
  input  logic [XLEN-1:0] IMM,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] INSTRUCTION,
  output logic            ERR
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StSecond = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [4:0]  li_rd_q, li_rd_d;
  logic [11:0] li_lo_q, li_lo_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;

  logic        is_li, li_fits, li_two, out_free, accept;
  logic [19:0] li_hi;

  logic [2:0]  p_format;
  logic [6:0]  p_opcode;
  logic [2:0]  p_funct3;
  logic [4:0]  p_rd, p_rs1, p_rs2;
  logic [31:0] p_imm, p_word;
  logic        p_err;

  assign is_li   = (FORMAT == FmtLi);
  assign li_fits = fits_signed(IMM, 12);
  assign li_two  = is_li && !li_fits;
  // Adding 0x800 before taking the upper bits only carries when IMM[11] is set.
  assign li_hi   = IMM[31:12] + {19'b0, IMM[11]};

  assign out_free = !out_valid_q || OUT_READY;
  assign IN_READY = RESET_N && (state_q == StIdle) && out_free;
  assign accept   = IN_VALID && IN_READY;

  // The single packer serves both the incoming request and the pending LI second beat.
  always_comb begin
    p_format = FORMAT;
    p_opcode = OPCODE;
    p_funct3 = FUNCT3;
    p_rd     = RD;
    p_rs1    = RS1;
    p_rs2    = RS2;
    p_imm    = IMM;
    if (state_q == StSecond) begin
      p_format = FmtI;
      p_opcode = OpcOpImm;
      p_funct3 = Funct3Addi;
      p_rd     = li_rd_q;
      p_rs1    = li_rd_q;
      p_imm    = {{20{li_lo_q[11]}}, li_lo_q};
    end else if (is_li) begin
      if (li_fits) begin
        p_format = FmtI;
        p_opcode = OpcOpImm;
        p_funct3 = Funct3Addi;
        p_rs1    = 5'd0;
      end else begin
        p_format = FmtU;
        p_opcode = OpcLui;
        p_imm    = {li_hi, 12'h000};
      end
    end
  end

  imm_field_pack u_pack (
    .format_i (p_format),
    .opcode_i (p_opcode),
    .funct3_i (p_funct3),
    .rd_i     (p_rd),
    .rs1_i    (p_rs1),
    .rs2_i    (p_rs2),
    .imm_i    (p_imm),
    .word_o   (p_word),
    .err_o    (p_err)
  );

  always_comb begin
    state_d     = state_q;
    li_rd_d     = li_rd_q;
    li_lo_d     = li_lo_q;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    if (state_q == StSecond) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        instr_d     = p_word;
        err_d       = p_err;
        state_d     = StIdle;
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      instr_d     = p_word;
      err_d       = p_err;
      if (li_two) begin
        state_d = StSecond;
        li_rd_d = RD;
        li_lo_d = IMM[11:0];
      end
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      li_rd_q     <= 5'd0;
      li_lo_q     <= 12'h000;
      out_valid_q <= 1'b0;
      instr_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      li_rd_q     <= li_rd_d;
      li_lo_q     <= li_lo_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
    end
  end

  assign OUT_VALID   = out_valid_q;
  assign INSTRUCTION = instr_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_immediate_encoder.sv
// Self-checking bench: directed cases plus randomized traffic against an arithmetic encoding model.
module tb_immediate_encoder;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        IN_VALID, IN_READY, OUT_VALID, OUT_READY, ERR;
  logic [2:0]  FORMAT, FUNCT3;
  logic [6:0]  OPCODE;
  logic [4:0]  RD, RS1, RS2;
  logic [31:0] IMM, INSTRUCTION;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] word;
    logic        err;
  } exp_t;
  exp_t q[$];

  immediate_encoder dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .FORMAT      (FORMAT),
    .OPCODE      (OPCODE),
    .FUNCT3      (FUNCT3),
    .RD          (RD),
    .RS1         (RS1),
    .RS2         (RS2),
    .IMM         (IMM),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .INSTRUCTION (INSTRUCTION),
    .ERR         (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bitv(input logic [31:0] v, input int pos);
    return (v >> pos) & 32'h1;
  endfunction

  // Reference encoder from the instruction-format rules, using signed ranges and shifts.
  function automatic void model(input logic [2:0] fmt, input logic [6:0] opc,
                                input logic [2:0] f3, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, output logic [31:0] w0,
                                output logic e0, output bit two, output logic [31:0] w1);
    int          s;
    logic [31:0] base, hi;
    s    = int'(imm);
    base = (32'(rd) << 7) | 32'(opc);
    two  = 1'b0;
    w1   = 32'h0;
    case (fmt)
      3'd0: begin
        w0 = (imm & 32'hFFFF_F000) | base;
        e0 = (imm & 32'hFFF) != 0;
      end
      3'd1: begin
        w0 = (bitv(imm, 20) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (bitv(imm, 11) << 20)
           | (((imm >> 12) & 32'hFF) << 12) | base;
        e0 = (s < -(1 << 20)) || (s >= (1 << 20)) || imm[0];
      end
      3'd2: begin
        w0 = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | base;
        e0 = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w0 = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
           | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(opc);
        e0 = (s < -2048) || (s > 2047);
      end
      3'd4: begin
        w0 = (bitv(imm, 12) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
           | (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8)
           | (bitv(imm, 11) << 7) | 32'(opc);
        e0 = (s < -4096) || (s > 4095) || imm[0];
      end
      3'd5: begin
        e0 = 1'b0;
        if (s >= -2048 && s <= 2047) begin
          w0 = ((imm & 32'hFFF) << 20) | (32'(rd) << 7) | 32'h13;
        end else begin
          hi  = (imm + 32'h800) >> 12;
          w0  = (hi << 12) | (32'(rd) << 7) | 32'h37;
          w1  = ((imm & 32'hFFF) << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
          two = 1'b1;
        end
      end
      default: begin
        w0 = 32'h0;
        e0 = 1'b1;
      end
    endcase
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit iv, input bit ordy, input logic [2:0] fmt,
                      input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    bit          exp_ready, consume, two;
    logic [31:0] w0, w1;
    logic        e0;
    check_eq("out_valid", OUT_VALID, 32'(q.size() > 0));
    if (q.size() > 0) begin
      check_eq("instruction", INSTRUCTION, q[0].word);
      check_eq("err", ERR, 32'(q[0].err));
    end
    IN_VALID = iv; OUT_READY = ordy; FORMAT = fmt; OPCODE = opc; FUNCT3 = f3;
    RD = rd; RS1 = rs1; RS2 = rs2; IMM = imm;
    #1;
    exp_ready = (q.size() == 0) || (q.size() == 1 && ordy);
    check_eq("in_ready", IN_READY, 32'(exp_ready));
    consume = (q.size() > 0) && ordy;
    @(posedge CLK);
    if (consume) void'(q.pop_front());
    if (iv && exp_ready) begin
      model(fmt, opc, f3, rd, rs1, rs2, imm, w0, e0, two, w1);
      q.push_back('{w0, e0});
      if (two) q.push_back('{w1, 1'b0});
    end
    @(negedge CLK);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, ordy, 3'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0);
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0:       return 32'($signed($urandom_range(0, 8191)) - 4096);
      1:       return $urandom & 32'hFFFF_F000;
      2:       return 32'($signed($urandom_range(0, 32'h3F_FFFF)) - 32'h20_0000);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    RESET_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; FORMAT = 3'd0; OPCODE = 7'd0;
    FUNCT3 = 3'd0; RD = 5'd0; RS1 = 5'd0; RS2 = 5'd0; IMM = 32'h0;
    repeat (2) @(negedge CLK);
    check_eq("rst_out_valid", OUT_VALID, 32'h0);
    check_eq("rst_instruction", INSTRUCTION, 32'h0);
    check_eq("rst_err", ERR, 32'h0);
    check_eq("rst_in_ready", IN_READY, 32'h0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Single-word I and B.
    step(1, 1, 3'd2, 7'b0010011, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
    check_eq("i_word", INSTRUCTION, 32'hFFF3_0293);
    check_eq("i_err", ERR, 32'h0);
    step(1, 1, 3'd4, 7'b1100011, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    check_eq("b_word", INSTRUCTION, 32'h0020_8463);
    check_eq("b_err", ERR, 32'h0);
    step(1, 1, 3'd4, 7'b1100011, 3'd0, 5'd0, 5'd1, 5'd2, 32'd7);
    check_eq("b_misalign_err", ERR, 32'h1);

    // LI two-beat, including the rounding case.
    step(1, 1, 3'd5, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5678);
    check_eq("li_lui", INSTRUCTION, 32'h1234_5537);
    step(1, 1, 3'd2, 7'b0010011, 3'd0, 5'd1, 5'd1, 5'd0, 32'd1);
    check_eq("li_addi", INSTRUCTION, 32'h6785_0513);
    step(1, 1, 3'd5, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h0000_0FFF);
    check_eq("li_round_lui", INSTRUCTION, 32'h0000_1537);
    idle(1'b1);
    check_eq("li_round_addi", INSTRUCTION, 32'hFFF5_0513);

    // LI single beat.
    step(1, 1, 3'd5, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'hFFFF_FFFB);
    check_eq("li_single", INSTRUCTION, 32'hFFB0_0513);
    idle(1'b1);
    idle(1'b1);

    // Backpressure on beat 1.
    step(1, 1, 3'd5, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5678);
    repeat (3) begin
      idle(1'b0);
      check_eq("bp_hold", INSTRUCTION, 32'h1234_5537);
    end
    idle(1'b1);
    check_eq("bp_beat2", INSTRUCTION, 32'h6785_0513);
    idle(1'b1);

    // Asynchronous reset while the second beat is pending.
    step(1, 0, 3'd5, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5678);
    #2 RESET_N = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", OUT_VALID, 32'h0);
    check_eq("mid_rst_instruction", INSTRUCTION, 32'h0);
    check_eq("mid_rst_in_ready", IN_READY, 32'h0);
    q.delete();
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) idle(1'b1);

    // Illegal format, then a normal request.
    step(1, 1, 3'd7, 7'h33, 3'd1, 5'd3, 5'd4, 5'd5, 32'h55);
    check_eq("illegal_word", INSTRUCTION, 32'h0);
    check_eq("illegal_err", ERR, 32'h1);
    step(1, 1, 3'd2, 7'b0010011, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
    check_eq("after_illegal", INSTRUCTION, 32'hFFF3_0293);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
           7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
    end
    repeat (4) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
